// File: rtl/clkctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller.
// Mode and FSM state types plus the prescaler counter width.
package clkctrl_pkg;

    typedef enum logic [1:0] {
        MODE_PAUSE = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10
    } state_e;

    localparam int PRE_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser, debouncer and rising-edge press detector.
// level follows the button after DB_CYCLES consecutive equal samples.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == 32'(DB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: pause / run / single-step / burst pacing.
// Define CLKCTRL_TICK_CNT_EN to build the tick_cnt pulse counter.
module cpu_clk_ctrl
    import clkctrl_pkg::*;
#(
    parameter int DIV0      = 1,
    parameter int DIV1      = 100000,
    parameter int DIV2      = 10000000,
    parameter int DIV3      = 100000000,
    parameter int DB_CYCLES = 1000000,
    parameter int HB_DIV    = 50000000,
    parameter int BURST_W   = 8,
    parameter int CNT_W     = 32
) (
    input  logic               CLK100MHZ,
    input  logic               RSTN,
    input  logic [1:0]         mode,
    input  logic [1:0]         rate_sel,
    input  logic               step_btn,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_ce,
    output logic               busy,
    output logic               heartbeat,
    output logic [CNT_W-1:0]   tick_cnt
);

    mode_e              md;
    state_e             state;
    logic [PRE_W-1:0]   div;
    logic [PRE_W-1:0]   pre;
    logic [31:0]        hb_cnt;
    logic [1:0]         mode_q;
    logic [1:0]         rate_q;
    logic               changed;
    logic               tick;
    logic               level;
    logic               press;
    logic               press_ev;
    logic [BURST_W-1:0] remain;

    assign md = mode_e'(mode);

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db (
        .clk  (CLK100MHZ),
        .rst_n(RSTN),
        .btn  (step_btn),
        .level(level),
        .press(press)
    );

    assign press_ev = press & level;

    always_comb begin
        div = PRE_W'(DIV0);
        unique case (rate_sel)
            2'd0: div = PRE_W'(DIV0);
            2'd1: div = PRE_W'(DIV1);
            2'd2: div = PRE_W'(DIV2);
            2'd3: div = PRE_W'(DIV3);
        endcase
    end

    // A tick from the old setting is dropped on the cycle a change lands.
    assign changed = (mode != mode_q) || (rate_sel != rate_q);
    assign tick    = !changed && (pre == div - PRE_W'(1));

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            mode_q <= 2'b00;
            rate_q <= 2'b00;
            pre    <= '0;
        end else begin
            mode_q <= mode;
            rate_q <= rate_sel;
            if (changed || pre >= div - PRE_W'(1)) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            cpu_ce <= 1'b0;
            busy   <= 1'b0;
            remain <= '0;
        end else begin
            cpu_ce <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    unique case (md)
                        MODE_PAUSE: ;
                        MODE_RUN:   state <= ST_RUN;
                        MODE_STEP:  cpu_ce <= press_ev;
                        MODE_BURST: begin
                            if (press_ev && burst_len != '0) begin
                                state  <= ST_BURST;
                                busy   <= 1'b1;
                                remain <= burst_len;
                            end
                        end
                    endcase
                end
                ST_RUN: begin
                    if (md != MODE_RUN) begin
                        state <= ST_IDLE;
                    end else begin
                        cpu_ce <= tick;
                    end
                end
                ST_BURST: begin
                    // busy drops one cycle after the final pulse.
                    if (md != MODE_BURST || remain == '0) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        remain <= '0;
                    end else if (tick) begin
                        cpu_ce <= 1'b1;
                        remain <= remain - BURST_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == 32'(HB_DIV - 1)) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end

`ifdef CLKCTRL_TICK_CNT_EN
    logic [CNT_W-1:0] tcnt;

    always_ff @(posedge CLK100MHZ or negedge RSTN) begin
        if (!RSTN) begin
            tcnt <= '0;
        end else if (cpu_ce) begin
            tcnt <= tcnt + CNT_W'(1);
        end
    end

    assign tick_cnt = tcnt;
`else
    assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with small dividers and debounce length.
module tb_cpu_clk_ctrl;

    logic       clk;
    logic       rstn;
    logic [1:0] mode;
    logic [1:0] rate_sel;
    logic       step_btn;
    logic [7:0] burst_len;
    logic       cpu_ce;
    logic       busy;
    logic       heartbeat;
    logic [31:0] tick_cnt;

    int checks;
    int failures;

`ifdef CLKCTRL_TICK_CNT_EN
    localparam int RUN_TICKS = 10;
`else
    localparam int RUN_TICKS = 0;
`endif

    cpu_clk_ctrl #(
        .DIV0(1), .DIV1(4), .DIV2(8), .DIV3(16),
        .DB_CYCLES(4), .HB_DIV(10),
        .BURST_W(8), .CNT_W(32)
    ) dut (
        .CLK100MHZ(clk),
        .RSTN     (rstn),
        .mode     (mode),
        .rate_sel (rate_sel),
        .step_btn (step_btn),
        .burst_len(burst_len),
        .cpu_ce   (cpu_ce),
        .busy     (busy),
        .heartbeat(heartbeat),
        .tick_cnt (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        checks++;
        if (cpu_ce !== 1'b0 || busy !== 1'b0 || heartbeat !== 1'b0) begin
            $display("FAIL reset_outs: ce=%b busy=%b hb=%b want 0", cpu_ce, busy, heartbeat);
            failures++;
        end
        checks++;
        if (tick_cnt !== 32'd0) begin
            $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt);
            failures++;
        end
        rstn = 1'b1;
        begin
            int n = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (cpu_ce) n++;
            end
            checks++;
            if (n != 0) begin
                $display("FAIL pause_after_reset: pulses %0d want 0", n);
                failures++;
            end
        end
    endtask

    task automatic test_run();
        int n = 0, first = -1, prev = -1, bad = 0;
        mode = 2'b01;
        rate_sel = 2'd1;
        // Prescaler clears on the change edge, so first pulse lands 4 later.
        for (int i = 0; i < 44; i++) begin
            step();
            if (cpu_ce) begin
                if (first < 0) first = i;
                else if (i - prev != 4) bad++;
                prev = i;
                n++;
            end
        end
        mode = 2'b00;
        checks++;
        if (first != 4) begin
            $display("FAIL run_first: got %0d want 4", first);
            failures++;
        end
        checks++;
        if (n != 10) begin
            $display("FAIL run_count: got %0d want 10", n);
            failures++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL run_spacing: bad gaps %0d want 0", bad);
            failures++;
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_ce) n++;
        end
        checks++;
        if (n != 0) begin
            $display("FAIL run_stop: pulses %0d want 0", n);
            failures++;
        end
        checks++;
        if (tick_cnt !== 32'(RUN_TICKS)) begin
            $display("FAIL run_tick_cnt: got %0d want %0d", tick_cnt, RUN_TICKS);
            failures++;
        end
    endtask

    task automatic test_pause();
        int n = 0;
        mode = 2'b00;
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cpu_ce) n++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_ce) n++;
        end
        checks++;
        if (n != 0) begin
            $display("FAIL pause_press: pulses %0d want 0", n);
            failures++;
        end
    endtask

    task automatic test_step();
        int n = 0, first = -1;
        mode = 2'b10;
        repeat (2) step();
        step_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_ce) begin
                if (first < 0) first = i;
                n++;
            end
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_ce) n++;
        end
        step_btn = 1'b1;
        repeat (2) begin
            step();
            if (cpu_ce) n++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_ce) n++;
        end
        checks++;
        if (n != 1) begin
            $display("FAIL step_count: got %0d want 1", n);
            failures++;
        end
        checks++;
        if (first != 6) begin
            $display("FAIL step_latency: got %0d want 6", first);
            failures++;
        end
    endtask

    task automatic test_burst();
        int n = 0, prev = -1, bad = 0, ce_nobusy = 0;
        int rise = -1, fall = -1, rises = 0;
        logic b_prev = 1'b0;
        mode = 2'b11;
        rate_sel = 2'd2;
        burst_len = 8'd3;
        repeat (4) step();
        step_btn = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (i == 6) step_btn = 1'b0;
            if (i == 8) burst_len = 8'd7;
            if (i == 14) step_btn = 1'b1;
            if (i == 26) step_btn = 1'b0;
            if (cpu_ce) begin
                if (prev >= 0 && i - prev != 8) bad++;
                if (!busy) ce_nobusy++;
                prev = i;
                n++;
            end
            if (busy && !b_prev) begin
                rises++;
                if (rise < 0) rise = i;
            end
            if (!busy && b_prev && fall < 0) fall = i;
            b_prev = busy;
        end
        checks++;
        if (n != 3) begin
            $display("FAIL burst_count: got %0d want 3", n);
            failures++;
        end
        checks++;
        if (bad != 0 || ce_nobusy != 0) begin
            $display("FAIL burst_spacing: bad gaps %0d ce_nobusy %0d want 0", bad, ce_nobusy);
            failures++;
        end
        checks++;
        if (rise != 6 || rises != 1) begin
            $display("FAIL burst_busy_rise: at %0d x%0d want 6 x1", rise, rises);
            failures++;
        end
        checks++;
        if (fall != prev + 1) begin
            $display("FAIL burst_busy_fall: at %0d want %0d", fall, prev + 1);
            failures++;
        end
    endtask

    task automatic test_burst_zero();
        int n = 0, bz = 0;
        burst_len = 8'd0;
        step_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 8) step_btn = 1'b0;
            if (cpu_ce) n++;
            if (busy) bz++;
        end
        checks++;
        if (n != 0 || bz != 0) begin
            $display("FAIL burst_zero: pulses %0d busy %0d want 0 0", n, bz);
            failures++;
        end
    endtask

    task automatic test_abort();
        int n = 0, first = -1, prev = -1, bad = 0, bz = 0;
        logic got2 = 1'b0;
        burst_len = 8'd5;
        step_btn = 1'b1;
        for (int i = 0; i < 60 && !got2; i++) begin
            step();
            if (i == 6) step_btn = 1'b0;
            if (cpu_ce) n++;
            if (n == 2) got2 = 1'b1;
        end
        step_btn = 1'b0;
        checks++;
        if (!got2) begin
            $display("FAIL abort_setup: pulses %0d want 2 within budget", n);
            failures++;
        end
        mode = 2'b01;
        n = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (j == 0) begin
                checks++;
                if (busy !== 1'b0 || cpu_ce !== 1'b0) begin
                    $display("FAIL abort_next: busy=%b ce=%b want 0 0", busy, cpu_ce);
                    failures++;
                end
            end
            if (busy) bz++;
            if (cpu_ce) begin
                if (first < 0) first = j;
                else if (j - prev != 8) bad++;
                prev = j;
                n++;
            end
        end
        mode = 2'b00;
        checks++;
        if (first != 8 || n != 4 || bad != 0) begin
            $display("FAIL abort_run: first %0d n %0d bad %0d want 8 4 0", first, n, bad);
            failures++;
        end
        checks++;
        if (bz != 0) begin
            $display("FAIL abort_busy: busy cycles %0d want 0", bz);
            failures++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_burst();
        int t = 0, first = -1, prev = -1, bad = 0, junk = 0;
        logic seen = 1'b0;
        logic hp = 1'b0;
        mode = 2'b11;
        rate_sel = 2'd2;
        burst_len = 8'd5;
        repeat (3) step();
        step_btn = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (i == 6) step_btn = 1'b0;
            if (cpu_ce) seen = 1'b1;
        end
        step_btn = 1'b0;
        checks++;
        if (!seen || busy !== 1'b1) begin
            $display("FAIL rst_setup: ce seen %b busy %b want 1 1", seen, busy);
            failures++;
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (cpu_ce !== 1'b0 || busy !== 1'b0 || heartbeat !== 1'b0 || tick_cnt !== 32'd0) begin
            $display("FAIL rst_async: ce=%b busy=%b hb=%b cnt=%0d want all 0",
                     cpu_ce, busy, heartbeat, tick_cnt);
            failures++;
        end
        repeat (3) step();
        rstn = 1'b1;
        for (int j = 0; j < 40; j++) begin
            step();
            if (heartbeat !== hp) begin
                if (first < 0) first = j;
                else if (j - prev != 10) bad++;
                prev = j;
                t++;
            end
            hp = heartbeat;
            if (busy || cpu_ce) junk++;
        end
        checks++;
        if (first != 9 || t != 4 || bad != 0) begin
            $display("FAIL hb_toggle: first %0d n %0d bad %0d want 9 4 0", first, t, bad);
            failures++;
        end
        checks++;
        if (junk != 0) begin
            $display("FAIL rst_idle: busy/ce cycles %0d want 0", junk);
            failures++;
        end
    endtask

    task automatic test_held_at_reset();
        int n = 0, first = -1;
        mode = 2'b10;
        step_btn = 1'b1;
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            if (cpu_ce) begin
                if (first < 0) first = j;
                n++;
            end
        end
        step_btn = 1'b0;
        checks++;
        if (n != 1 || first != 6) begin
            $display("FAIL held_at_reset: n %0d first %0d want 1 6", n, first);
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        mode = 2'b00;
        rate_sel = 2'd0;
        step_btn = 1'b0;
        burst_len = 8'd0;
        test_reset();
        test_run();
        test_pause();
        test_step();
        test_burst();
        test_burst_zero();
        test_abort();
        test_reset_mid_burst();
        test_held_at_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning) as REQ-002..REQ-007.
REQ-002 DIV0, 1: clocks per cpu_ce in rate 0 (full speed).
REQ-003 DIV1, 100000; DIV2, 10000000; DIV3, 100000000: clocks per cpu_ce in rates 1-3; each >=1.
REQ-004 DB_CYCLES, 1000000: stable cycles required before a step_btn level is accepted.
REQ-005 HB_DIV, 50000000: clocks per heartbeat toggle.
REQ-006 BURST_W, 8: burst_len width.
REQ-007 CNT_W, 32: tick_cnt width.
REQ-008 CLK100MHZ  in  1  sole clock, all logic on its rising edge.
REQ-009 RSTN  in  1  asynchronous, active-low reset.
REQ-010 mode  in  2  00 PAUSE, 01 RUN, 10 STEP, 11 BURST.
REQ-011 rate_sel  in  2  selects DIV0..DIV3.
REQ-012 step_btn  in  1  raw asynchronous push button, active high.
REQ-013 burst_len  in  BURST_W  cpu_ce pulses per burst.
REQ-014 cpu_ce  out  1  one-cycle CPU clock-enable pulse.
REQ-015 busy  out  1  high while a burst is in progress.
REQ-016 heartbeat  out  1  free-running square wave for an LED.
REQ-017 tick_cnt  out  CNT_W  total cpu_ce pulses issued, wrapping.

Function
REQ-018 SHALL never gate or divide the clock; CPU pacing SHALL be via cpu_ce only.
REQ-019 SHALL synchronise step_btn through 2 flops, then debounce: accepted level changes only after DB_CYCLES consecutive equal samples.
REQ-020 SHALL generate a press event, one cycle wide, on each accepted 0->1 transition; releases generate no event.
REQ-021 Prescaler SHALL count 0..DIV(rate_sel)-1; cpu_ce-eligible tick on terminal count; DIV=1 gives a tick every cycle.
REQ-022 Prescaler SHALL clear to 0 the cycle after any change of rate_sel or mode.
REQ-023 FSM states: IDLE, RUN, BURST; mode PAUSE or STEP SHALL select IDLE, mode RUN SHALL select RUN.
REQ-024 RUN: cpu_ce SHALL assert on every prescaler tick.
REQ-025 IDLE with mode STEP: each press event SHALL produce exactly one cpu_ce on the following cycle, independent of the prescaler.
REQ-026 IDLE with mode PAUSE: cpu_ce SHALL remain 0; press events ignored.
REQ-027 Mode BURST: press event with burst_len!=0 SHALL latch burst_len, enter BURST, assert busy, and issue one cpu_ce per prescaler tick until the latched count is exhausted, then return to IDLE with busy low the cycle after the last pulse.
REQ-028 burst_len=0 SHALL produce no pulses and no busy.
REQ-029 Press events during BURST SHALL be ignored; burst_len changes during BURST SHALL have no effect.
REQ-030 A mode change during BURST SHALL abort it the next cycle: no further pulses, busy low.
REQ-031 heartbeat SHALL toggle every HB_DIV cycles irrespective of mode.
REQ-032 tick_cnt SHALL increment by 1 in the cycle after each cpu_ce, wrapping from all-ones to 0.

Reset
REQ-033 RSTN low SHALL immediately force cpu_ce=0, busy=0, heartbeat=0, tick_cnt=0, FSM=IDLE, prescaler=0, debounced level=0, and clear all counters, including mid-burst.
REQ-034 A button already held at reset release SHALL yield one press event once debounced.

Configuration
REQ-035 With CLKCTRL_TICK_CNT_EN defined, tick_cnt SHALL behave per REQ-032.
REQ-036 Without CLKCTRL_TICK_CNT_EN, tick_cnt SHALL be constant 0 and its counter SHALL not be synthesised.

Structure
REQ-037 Package clkctrl_pkg SHALL hold the mode encodings and FSM state encodings.
REQ-038 Debounce/edge logic SHALL be a sub-module btn_debounce (parameter DB_CYCLES; outputs level and press pulse).

Verification (DIV0=1, DIV1=4, DIV2=8, DIV3=16, DB_CYCLES=4, HB_DIV=10)
REQ-039 RUN, rate_sel=1 for 40 cycles -> 10 cpu_ce pulses, exactly 4 cycles apart; tick_cnt=10.
REQ-040 STEP, press held 10 cycles then 2-cycle glitch -> exactly 1 cpu_ce; glitch ignored.
REQ-041 BURST, burst_len=3, rate 2, one press -> 3 pulses 8 cycles apart, busy high throughout, low after last.
REQ-042 BURST, burst_len=5, mode->RUN after 2 pulses -> abort, busy low next cycle, then RUN pulses every tick.
REQ-043 RSTN low mid-burst -> cpu_ce, busy, tick_cnt, heartbeat 0 immediately; after release heartbeat toggles every 10 cycles.
